// File: rtl/titan_wb_arbiter.sv
// Two-master Wishbone arbiter: instruction (iwbm) and data (dwbm) masters share one slave port.
// Optional watchdog enabled by defining TITAN_ARB_TIMEOUT_EN.
module titan_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] iwbm_addr_i,
   input  logic        iwbm_cyc_i,
   input  logic        iwbm_stb_i,
   output logic [31:0] iwbm_dat_o,
   output logic        iwbm_ack_o,
   output logic        iwbm_err_o,
   input  logic [31:0] dwbm_addr_i,
   input  logic [31:0] dwbm_dat_i,
   input  logic [3:0]  dwbm_sel_i,
   input  logic        dwbm_we_i,
   input  logic        dwbm_cyc_i,
   input  logic        dwbm_stb_i,
   output logic [31:0] dwbm_dat_o,
   output logic        dwbm_ack_o,
   output logic        dwbm_err_o,
   output logic [31:0] swbm_addr_o,
   output logic [31:0] swbm_dat_o,
   output logic [3:0]  swbm_sel_o,
   output logic        swbm_we_o,
   output logic        swbm_cyc_o,
   output logic        swbm_stb_o,
   input  logic [31:0] swbm_dat_i,
   input  logic        swbm_ack_i,
   input  logic        swbm_err_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t state_r;
   state_t state_s;
   logic   last_d_r;   // 1: data master was granted last
   logic   req_i_s;
   logic   req_d_s;
   logic   wd_fire_s;
   logic   term_s;

   assign req_i_s = iwbm_cyc_i & iwbm_stb_i;
   assign req_d_s = dwbm_cyc_i & dwbm_stb_i;

`ifdef TITAN_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt_r;

   // Watchdog: cleared while idle (so it starts at zero on grant entry), counts silent granted cycles
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wd_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == IDLE) begin
         wd_cnt_r <= {CNT_W{1'b0}};
      end else if (!swbm_ack_i && !swbm_err_i) begin
         wd_cnt_r <= wd_cnt_r + CNT_W'(1);
      end else begin
         wd_cnt_r <= wd_cnt_r;
      end
   end

   // A real slave response in the firing cycle wins over the watchdog
   assign wd_fire_s = (state_r != IDLE) && (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                      !swbm_ack_i && !swbm_err_i;
`else
   // Watchdog compiled out; the parameter stays referenced so it remains part of the interface
   assign wd_fire_s = 1'b0 && (TIMEOUT_CYCLES >= 2);
`endif

   assign term_s = swbm_ack_i | swbm_err_i | wd_fire_s;

   // State and fairness pointer registers; pointer updates only on grant entry
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r  <= IDLE;
         last_d_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if (state_r == IDLE && state_s == GNT_D) begin
            last_d_r <= 1'b1;
         end else if (state_r == IDLE && state_s == GNT_I) begin
            last_d_r <= 1'b0;
         end else begin
            last_d_r <= last_d_r;
         end
      end
   end

   // Next-state and output multiplexing
   always_comb begin
      state_s     = state_r;
      swbm_addr_o = 32'h0000_0000;
      swbm_dat_o  = 32'h0000_0000;
      swbm_sel_o  = 4'h0;
      swbm_we_o   = 1'b0;
      swbm_cyc_o  = 1'b0;
      swbm_stb_o  = 1'b0;
      iwbm_ack_o  = 1'b0;
      iwbm_err_o  = 1'b0;
      dwbm_ack_o  = 1'b0;
      dwbm_err_o  = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_i_s && req_d_s) begin
               state_s = last_d_r ? GNT_I : GNT_D;
            end else if (req_d_s) begin
               state_s = GNT_D;
            end else if (req_i_s) begin
               state_s = GNT_I;
            end else begin
               state_s = IDLE;
            end
         end
         GNT_I: begin
            swbm_addr_o = iwbm_addr_i;
            swbm_sel_o  = 4'hF;
            swbm_cyc_o  = iwbm_cyc_i & ~wd_fire_s;
            swbm_stb_o  = iwbm_stb_i & ~wd_fire_s;
            iwbm_ack_o  = swbm_ack_i & ~swbm_err_i;
            iwbm_err_o  = swbm_err_i | wd_fire_s;
            if (!iwbm_cyc_i || term_s) begin
               state_s = IDLE;
            end else begin
               state_s = GNT_I;
            end
         end
         GNT_D: begin
            swbm_addr_o = dwbm_addr_i;
            swbm_dat_o  = dwbm_dat_i;
            swbm_sel_o  = dwbm_sel_i;
            swbm_we_o   = dwbm_we_i;
            swbm_cyc_o  = dwbm_cyc_i & ~wd_fire_s;
            swbm_stb_o  = dwbm_stb_i & ~wd_fire_s;
            dwbm_ack_o  = swbm_ack_i & ~swbm_err_i;
            dwbm_err_o  = swbm_err_i | wd_fire_s;
            if (!dwbm_cyc_i || term_s) begin
               state_s = IDLE;
            end else begin
               state_s = GNT_D;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Read data is shared by both masters; forced low while reset is held
   always_comb begin
      if (rst_i) begin
         iwbm_dat_o = swbm_dat_i;
         dwbm_dat_o = swbm_dat_i;
      end else begin
         iwbm_dat_o = 32'h0000_0000;
         dwbm_dat_o = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_titan_wb_arbiter.sv
// Directed self-checking bench for titan_wb_arbiter (default build and TITAN_ARB_TIMEOUT_EN build).
module tb_titan_wb_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] iwbm_addr_i;
   logic        iwbm_cyc_i, iwbm_stb_i;
   logic [31:0] iwbm_dat_o;
   logic        iwbm_ack_o, iwbm_err_o;
   logic [31:0] dwbm_addr_i, dwbm_dat_i;
   logic [3:0]  dwbm_sel_i;
   logic        dwbm_we_i, dwbm_cyc_i, dwbm_stb_i;
   logic [31:0] dwbm_dat_o;
   logic        dwbm_ack_o, dwbm_err_o;
   logic [31:0] swbm_addr_o, swbm_dat_o;
   logic [3:0]  swbm_sel_o;
   logic        swbm_we_o, swbm_cyc_o, swbm_stb_o;
   logic [31:0] swbm_dat_i;
   logic        swbm_ack_i, swbm_err_i;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   titan_wb_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .iwbm_addr_i(iwbm_addr_i), .iwbm_cyc_i(iwbm_cyc_i), .iwbm_stb_i(iwbm_stb_i),
      .iwbm_dat_o(iwbm_dat_o), .iwbm_ack_o(iwbm_ack_o), .iwbm_err_o(iwbm_err_o),
      .dwbm_addr_i(dwbm_addr_i), .dwbm_dat_i(dwbm_dat_i), .dwbm_sel_i(dwbm_sel_i),
      .dwbm_we_i(dwbm_we_i), .dwbm_cyc_i(dwbm_cyc_i), .dwbm_stb_i(dwbm_stb_i),
      .dwbm_dat_o(dwbm_dat_o), .dwbm_ack_o(dwbm_ack_o), .dwbm_err_o(dwbm_err_o),
      .swbm_addr_o(swbm_addr_o), .swbm_dat_o(swbm_dat_o), .swbm_sel_o(swbm_sel_o),
      .swbm_we_o(swbm_we_o), .swbm_cyc_o(swbm_cyc_o), .swbm_stb_o(swbm_stb_o),
      .swbm_dat_i(swbm_dat_i), .swbm_ack_i(swbm_ack_i), .swbm_err_i(swbm_err_i)
   );

   task automatic clear_inputs();
      iwbm_addr_i = 32'h0; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0;
      dwbm_addr_i = 32'h0; dwbm_dat_i = 32'h0; dwbm_sel_i = 4'h0;
      dwbm_we_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
      swbm_dat_i = 32'h0; swbm_ack_i = 1'b0; swbm_err_i = 1'b0;
   endtask

   task automatic apply_reset();
      rst_i = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      logic [138:0] all_out;
      rst_i = 1'b0;
      iwbm_addr_i = 32'h0000_0100; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      dwbm_addr_i = 32'h0000_0200; dwbm_dat_i = 32'h0000_0055; dwbm_sel_i = 4'hC;
      dwbm_we_i = 1'b1; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      swbm_dat_i = 32'h1234_5678; swbm_ack_i = 1'b1; swbm_err_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #2;
      all_out = {swbm_addr_o, swbm_dat_o, swbm_sel_o, swbm_we_o, swbm_cyc_o, swbm_stb_o,
                 iwbm_dat_o, iwbm_ack_o, iwbm_err_o, dwbm_dat_o, dwbm_ack_o, dwbm_err_o};
      tests++;
      if (all_out !== 139'h0) begin
         fails++;
         $display("FAIL reset_outputs got=%h want=0", all_out);
      end
      swbm_ack_i = 1'b0; swbm_err_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      tests++;
      if (swbm_cyc_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_release_latency swbm_cyc_o=%b want=0", swbm_cyc_o);
      end
      tick();
      tests++;
      if ({swbm_cyc_o, swbm_we_o, swbm_addr_o} !== {1'b1, 1'b1, 32'h0000_0200}) begin
         fails++;
         $display("FAIL reset_first_grant cyc/we/addr=%b/%b/%h want=1/1/00000200",
                  swbm_cyc_o, swbm_we_o, swbm_addr_o);
      end
      tests++;
      if (dwbm_dat_o !== 32'h1234_5678) begin
         fails++;
         $display("FAIL reset_dat_pass got=%h want=12345678", dwbm_dat_o);
      end
      clear_inputs();
   endtask

   task automatic test_tie_alternation();
      bit exp_d;
      logic [31:0] exp_addr;
      apply_reset();
      iwbm_addr_i = 32'h0000_0100; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      dwbm_addr_i = 32'h0000_0200; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      for (int g = 0; g < 4; g++) begin
         exp_d = (g % 2 == 0);
         exp_addr = exp_d ? 32'h0000_0200 : 32'h0000_0100;
         tick();
         swbm_ack_i = 1'b1;
         #1;
         tests++;
         if ({swbm_cyc_o, swbm_addr_o} !== {1'b1, exp_addr}) begin
            fails++;
            $display("FAIL tie_grant%0d cyc/addr=%b/%h want=1/%h", g, swbm_cyc_o, swbm_addr_o, exp_addr);
         end
         tests++;
         if ({iwbm_ack_o, dwbm_ack_o} !== {~exp_d, exp_d}) begin
            fails++;
            $display("FAIL tie_ack%0d i/d=%b%b want=%b%b", g, iwbm_ack_o, dwbm_ack_o, ~exp_d, exp_d);
         end
         tick();
         swbm_ack_i = 1'b0;
         #1;
         tests++;
         if ({swbm_cyc_o, iwbm_ack_o, dwbm_ack_o} !== 3'b000) begin
            fails++;
            $display("FAIL tie_idle%0d cyc/iack/dack=%b%b%b want=000", g, swbm_cyc_o, iwbm_ack_o, dwbm_ack_o);
         end
      end
      clear_inputs();
   endtask

   task automatic test_write();
      apply_reset();
      dwbm_addr_i = 32'h8000_0010; dwbm_dat_i = 32'hDEAD_BEEF; dwbm_sel_i = 4'b0011;
      dwbm_we_i = 1'b1; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      tick();
      tests++;
      if ({swbm_addr_o, swbm_dat_o, swbm_sel_o, swbm_we_o, swbm_cyc_o, swbm_stb_o} !==
          {32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL write_pass addr=%h dat=%h sel=%b we=%b cyc=%b stb=%b want 80000010 deadbeef 0011 1 1 1",
                  swbm_addr_o, swbm_dat_o, swbm_sel_o, swbm_we_o, swbm_cyc_o, swbm_stb_o);
      end
      tests++;
      if (dwbm_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL write_no_early_ack got=%b want=0", dwbm_ack_o);
      end
      tick();
      swbm_ack_i = 1'b1;
      #1;
      tests++;
      if ({dwbm_ack_o, iwbm_ack_o, swbm_cyc_o} !== 3'b101) begin
         fails++;
         $display("FAIL write_ack dack/iack/cyc=%b%b%b want=101", dwbm_ack_o, iwbm_ack_o, swbm_cyc_o);
      end
      tick();
      swbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
      #1;
      tests++;
      if ({swbm_cyc_o, dwbm_ack_o} !== 2'b00) begin
         fails++;
         $display("FAIL write_idle cyc/dack=%b%b want=00", swbm_cyc_o, dwbm_ack_o);
      end
      clear_inputs();
   endtask

   task automatic test_slave_error();
      apply_reset();
      iwbm_addr_i = 32'h0000_0040; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      dwbm_dat_i = 32'hFFFF_FFFF; dwbm_we_i = 1'b1; dwbm_sel_i = 4'h1;
      swbm_dat_i = 32'hCAFE_F00D;
      tick();
      tests++;
      if ({swbm_addr_o, swbm_dat_o, swbm_sel_o, swbm_we_o, swbm_cyc_o} !==
          {32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL ifetch_drive addr=%h dat=%h sel=%h we=%b cyc=%b want 00000040 0 f 0 1",
                  swbm_addr_o, swbm_dat_o, swbm_sel_o, swbm_we_o, swbm_cyc_o);
      end
      tick();
      swbm_err_i = 1'b1;
      #1;
      tests++;
      if ({iwbm_err_o, iwbm_ack_o, dwbm_err_o} !== 3'b100) begin
         fails++;
         $display("FAIL slave_err ierr/iack/derr=%b%b%b want=100", iwbm_err_o, iwbm_ack_o, dwbm_err_o);
      end
      tests++;
      if (iwbm_dat_o !== 32'hCAFE_F00D) begin
         fails++;
         $display("FAIL err_dat got=%h want=cafef00d", iwbm_dat_o);
      end
      tick();
      swbm_err_i = 1'b0; swbm_dat_i = 32'h0BAD_0BAD;
      #1;
      tests++;
      if ({iwbm_err_o, swbm_cyc_o} !== 2'b00) begin
         fails++;
         $display("FAIL err_then_idle ierr/cyc=%b%b want=00", iwbm_err_o, swbm_cyc_o);
      end
      tests++;
      if (iwbm_dat_o !== 32'h0BAD_0BAD) begin
         fails++;
         $display("FAIL idle_dat got=%h want=0bad0bad", iwbm_dat_o);
      end
      tick();
      swbm_ack_i = 1'b1; swbm_err_i = 1'b1;
      #1;
      tests++;
      if ({iwbm_ack_o, iwbm_err_o, swbm_cyc_o} !== 3'b011) begin
         fails++;
         $display("FAIL ack_err_both iack/ierr/cyc=%b%b%b want=011", iwbm_ack_o, iwbm_err_o, swbm_cyc_o);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_abort_and_reset();
      apply_reset();
      dwbm_addr_i = 32'h0000_0200; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      tick();
      iwbm_addr_i = 32'h0000_0100; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      tick();
      tests++;
      if ({swbm_cyc_o, swbm_addr_o} !== {1'b1, 32'h0000_0200}) begin
         fails++;
         $display("FAIL no_preempt cyc/addr=%b/%h want=1/00000200", swbm_cyc_o, swbm_addr_o);
      end
      dwbm_cyc_i = 1'b0;
      #1;
      tests++;
      if (swbm_cyc_o !== 1'b0) begin
         fails++;
         $display("FAIL abort_same_cycle cyc=%b want=0", swbm_cyc_o);
      end
      tick();
      tests++;
      if (swbm_cyc_o !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle cyc=%b want=0", swbm_cyc_o);
      end
      tick();
      tests++;
      if ({swbm_cyc_o, swbm_addr_o} !== {1'b1, 32'h0000_0100}) begin
         fails++;
         $display("FAIL abort_regrant cyc/addr=%b/%h want=1/00000100", swbm_cyc_o, swbm_addr_o);
      end
      swbm_ack_i = 1'b1;
      #1;
      tests++;
      if (iwbm_ack_o !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset_ack got=%b want=1", iwbm_ack_o);
      end
      rst_i = 1'b0;
      #1;
      tests++;
      if ({swbm_cyc_o, iwbm_ack_o} !== 2'b00) begin
         fails++;
         $display("FAIL midgrant_reset cyc/iack=%b%b want=00", swbm_cyc_o, iwbm_ack_o);
      end
      clear_inputs();
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_watchdog();
`ifdef TITAN_ARB_TIMEOUT_EN
      bit exp_err;
      apply_reset();
      dwbm_addr_i = 32'h0000_0200; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      for (int k = 1; k <= TB_TIMEOUT; k++) begin
         exp_err = (k == TB_TIMEOUT);
         tick();
         tests++;
         if ({dwbm_err_o, swbm_cyc_o, swbm_stb_o} !== {exp_err, ~exp_err, ~exp_err}) begin
            fails++;
            $display("FAIL wd_cycle%0d derr/cyc/stb=%b%b%b want=%b%b%b", k,
                     dwbm_err_o, swbm_cyc_o, swbm_stb_o, exp_err, ~exp_err, ~exp_err);
         end
      end
      tick();
      tests++;
      if ({swbm_cyc_o, dwbm_err_o} !== 2'b00) begin
         fails++;
         $display("FAIL wd_idle cyc/derr=%b%b want=00", swbm_cyc_o, dwbm_err_o);
      end
      clear_inputs();
      tick();
`else
      int drops;
      drops = 0;
      apply_reset();
      dwbm_addr_i = 32'h0000_0200; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      repeat (120) begin
         tick();
         if (swbm_cyc_o !== 1'b1 || dwbm_err_o !== 1'b0) drops++;
      end
      tests++;
      if (drops !== 0) begin
         fails++;
         $display("FAIL hold_no_watchdog dropped_cycles=%0d want=0", drops);
      end
      clear_inputs();
      tick();
      tests++;
      if (swbm_cyc_o !== 1'b0) begin
         fails++;
         $display("FAIL hold_release cyc=%b want=0", swbm_cyc_o);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL tb_timeout simulation did not complete");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      rst_i = 1'b0;
      test_reset();
      test_tie_alternation();
      test_write();
      test_slave_error();
      test_abort_and_reset();
      test_watchdog();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/titan_wb_arbiter.md
# titan_wb_arbiter

Two-master Wishbone arbiter that shares one external memory slave port between the core's instruction port (iwbm) and data port (dwbm). It sits between the core and a unified memory/bus, alternating access fairly and holding each grant for a whole bus cycle. An optional watchdog terminates hung cycles with an error.

## Interface
- TIMEOUT_CYCLES, 255: granted cycles without ack/err before the watchdog fires; must be ≥2. Only used when the watchdog is compiled in.
- clk_i  in  1  single clock for the block.
- rst_i  in  1  reset, asynchronous and active-low.
- iwbm_addr_i  in  32  instruction master address.
- iwbm_cyc_i, iwbm_stb_i  in  1  instruction master cycle and strobe.
- iwbm_dat_o  out  32  read data to the instruction master; equals swbm_dat_i.
- iwbm_ack_o, iwbm_err_o  out  1  instruction master termination.
- dwbm_addr_i  in  32  data master address.
- dwbm_dat_i  in  32  data master write data.
- dwbm_sel_i  in  4  data master byte select.
- dwbm_we_i, dwbm_cyc_i, dwbm_stb_i  in  1  data master write enable, cycle and strobe.
- dwbm_dat_o  out  32  read data to the data master; equals swbm_dat_i.
- dwbm_ack_o, dwbm_err_o  out  1  data master termination.
- swbm_addr_o  out  32  shared slave address.
- swbm_dat_o  out  32  shared slave write data.
- swbm_sel_o  out  4  shared slave byte select.
- swbm_we_o, swbm_cyc_o, swbm_stb_o  out  1  shared slave write enable, cycle and strobe.
- swbm_dat_i  in  32  shared slave read data.
- swbm_ack_i, swbm_err_i  in  1  shared slave termination.

## Operation
- Requests: a master requests when its cyc_i and stb_i are both 1.
- FSM states: IDLE, GNT_I, GNT_D. The state register and the `last` pointer (last granted master: I or D) are the only arbitration state.
- IDLE, only one master requesting: go to that master's grant state.
- IDLE, both requesting: grant the master not equal to `last`. Reset sets `last` = I, so the data master wins the first tie.
- Entering a grant state updates `last`.
- GNT_x, slave side: swbm_* outputs carry master x's signals. The instruction master drives swbm_we_o=0, swbm_sel_o=4'hF and swbm_dat_o=0.
- GNT_x, master side: x_ack_o = swbm_ack_i and x_err_o = swbm_err_i. The other master's ack and err are held at 0.
- IDLE: all swbm_* outputs are 0, and every ack and err output is 0.
- Leaving a grant: swbm_ack_i or swbm_err_i while granted returns to IDLE at that edge.
- Abort: the granted master deasserting cyc_i returns to IDLE at the next edge. swbm_cyc_o follows the master combinationally, so it drops in the same cycle.
- Read data passes through unregistered to both masters; only the granted master's ack qualifies it.

## Timing
- Reset (rst_i=0, asynchronous): state=IDLE, `last`=I, watchdog counter=0. Every output is 0 while reset is asserted.
- Reset asserted mid-cycle: swbm_cyc_o drops immediately and the slave response is discarded.
- Grant latency: a request sampled in IDLE at edge N gives swbm_cyc_o=1 during cycle N+1.
- Back-to-back: after each termination there is one mandatory IDLE cycle. Minimum spacing between transactions is therefore grant cycle + IDLE cycle.
- Termination: ack/err to the master is combinational from the slave in the same cycle, with zero added latency.
- Simultaneous ack and err: the err path is forwarded, and ack is suppressed to the master.
- A new request arriving during a grant waits; there is no preemption.

## Configuration
- Macro: TITAN_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to a grant state and increments each granted cycle without ack/err.
  - When the count reaches TIMEOUT_CYCLES, the block asserts x_err_o=1 to the granted master for that cycle, forces swbm_cyc_o and swbm_stb_o to 0, and returns to IDLE.
  - A slave ack/err arriving in the same cycle takes precedence and is forwarded normally.
- When undefined: there is no counter and a grant is held indefinitely until ack/err/abort. The TIMEOUT_CYCLES parameter is ignored.

## Test plan
- Reset: hold rst_i=0 with both masters requesting -> all outputs 0. Release reset -> dwbm is granted (swbm_we_o follows dwbm_we_i) in the cycle after the first sampled edge.
- Tie alternation: both masters request continuously and the slave acks 1 cycle after each grant -> grant order D, I, D, I with one IDLE cycle between grants. iwbm_ack_o and dwbm_ack_o are never 1 in the same cycle.
- Write pass-through: dwbm addr=0x8000_0010, dat=0xDEAD_BEEF, sel=4'b0011, we=1 -> swbm outputs show the same values. dwbm_ack_o pulses with swbm_ack_i, and iwbm_ack_o stays 0.
- Slave error: iwbm granted and slave returns err=1 -> iwbm_err_o=1 for 1 cycle, then IDLE. iwbm_dat_o equals swbm_dat_i throughout.
- Abort and reset: dwbm drops cyc_i mid-grant -> swbm_cyc_o=0 in the same cycle and a pending iwbm request is granted 1 cycle later. Asserting rst_i=0 mid-grant -> swbm_cyc_o=0 immediately.
- Watchdog (TITAN_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave silent) -> the granted master's err_o=1 on the 4th granted cycle, followed by IDLE. Without the macro, the grant holds for more than 100 cycles.
